// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing the single-ported data ram; round-robin, or fixed port-0 priority with `MEM_ARB_FIXED_PRIO_EN.
// Latency: handshake at E0, ram strobed E0..E1, ack/rdata/err E1..E2; at most one access per 3 cycles.
// Backpressure: gnt only while IDLE; a requester holds req and its fields until it sees its gnt bit.
module mem_arbiter #(
    parameter int DEPTH = 512,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [1:0]    wr,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_t        state, state_nxt;
    logic          hs;
    logic          hs_id;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          id_q;
    logic          wr_q;
    logic          oor_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Port granted at the most recent handshake; reset to 1 so port 0 wins first.
    logic last;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (hs)
            last <= hs_id;
    end
`endif

    always_comb begin
        gnt       = 2'b00;
        state_nxt = state;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                case (req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                        gnt = 2'b01;
`else
                        gnt = last ? 2'b01 : 2'b10;
`endif
                    end
                    default: gnt = 2'b00;
                endcase
                if ((req & gnt) != 2'b00)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                // Gating by rst_n keeps a reset landing mid-access from committing a write.
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                ram_write = wr_q & ~oor_q & rst_n;
                ram_read  = ~wr_q & ~oor_q & rst_n;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hs        = (req & gnt) != 2'b00;
    assign hs_id     = gnt[1];
    assign sel_wr    = hs_id ? wr[1]  : wr[0];
    assign sel_addr  = hs_id ? addr1  : addr0;
    assign sel_wdata = hs_id ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ack     <= 2'b00;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= 2'b00;
            err   <= 1'b0;
            if (hs) begin
                id_q    <= hs_id;
                wr_q    <= sel_wr;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                oor_q   <= sel_addr >= DEPTH_W;
            end
            if (state == ACCESS) begin
                rdata <= (!wr_q && !oor_q) ? ram_rdata : '0;
                ack   <= id_q ? 2'b10 : 2'b01;
                err   <= oor_q;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural ram, scoreboard of expected responses, directed steps.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int DEPTH = 512;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, wr;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, ack;
    logic [31:0] rdata;
    logic        err, ram_read, ram_write;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem    [DEPTH];
    logic [31:0] shadow [DEPTH];
    logic        ram_ready = 1'b0;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    exp_t        e_pop;
    int          acks_expected = 0;
    int          ack_cnt = 0;
    int          ack_cyc = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    int          hs_port[$];
    int          hs_cyc[$];

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack(ack), .rdata(rdata), .err(err),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-ported ram with combinational read.
    assign ram_rdata = (ram_addr < DEPTH) ? mem[ram_addr[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000_0000 + i;
            ram_ready <= 1'b1;
        end else if (ram_write && ram_addr < DEPTH) begin
            mem[ram_addr[8:0]] <= ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake and strobe monitor, sampling pre-edge values.
    always @(posedge clk) begin
        if (rst_n && (req & gnt) != 2'b00) begin
            hs_port.push_back(gnt[1] ? 1 : 0);
            hs_cyc.push_back(cyc);
        end
        if (ram_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
        end
        if (ram_read) rd_cnt <= rd_cnt + 1;
        cyc <= cyc + 1;
    end

    // Response checker: every ack pops one expected response.
    always @(negedge clk) begin
        if (ack != 2'b00) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", {30'b0, ack}, 32'h0);
            end else begin
                e_pop = sb.pop_front();
                check("ack_port", {30'b0, ack}, (e_pop.port == 1) ? 32'h2 : 32'h1);
                check("rdata", rdata, e_pop.rdata);
                check("err", {31'b0, err}, {31'b0, e_pop.err});
            end
            ack_cnt <= ack_cnt + 1;
            ack_cyc <= cyc;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge (FSM in ACCESS).
    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic expect_ack, output int waits);
        exp_t e;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        wr[p]  = w;
        req[p] = 1'b1;
        if (expect_ack) begin
            e.port  = p;
            e.rdata = (w || a >= DEPTH) ? 32'h0 : shadow[a[8:0]];
            e.err   = (a >= DEPTH);
            sb.push_back(e);
            acks_expected++;
            if (w && a < DEPTH) shadow[a[8:0]] = d;
        end
        waits = 0;
        #1;
        while (!gnt[p] && waits < 20) begin
            @(posedge clk); #2;
            waits++;
        end
        if (!gnt[p]) check("gnt_timeout", {30'b0, gnt}, 32'h1 << p);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic wait_acks();
        int n;
        n = 0;
        while (ack_cnt < acks_expected && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (ack_cnt < acks_expected) check("ack_timeout", ack_cnt, acks_expected);
    endtask

    initial begin
        int w, wr0, rd0, hs0, hsi;
        int order[4];
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h1000_0000 + i;
        rst_n = 1'b0; req = 2'b00; wr = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset then idle.
        @(posedge clk); @(posedge clk); #1;
        check("rst_gnt", {30'b0, gnt}, 32'h0);
        check("rst_ack", {30'b0, ack}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_strobes", {30'b0, ram_read, ram_write}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Port 1 writes 0xDEADBEEF to 5, then port 0 reads it back.
        wr0 = wr_cnt;
        access(1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b1, w);
        wait_acks();
        check("wr_pulse_count", wr_cnt - wr0, 1);
        check("wr_pulse_addr", last_wr_addr, 32'd5);
        check("ram_word5", mem[5], 32'hDEAD_BEEF);
        access(0, 1'b0, 32'd5, 32'h0, 1'b1, w);
        wait_acks();
        check("read_latency", ack_cyc - hs_cyc[hs_cyc.size()-1], 2);

        // Out-of-range read never strobes ram.
        rd0 = rd_cnt;
        access(0, 1'b0, 32'd512, 32'h0, 1'b1, w);
        wait_acks();
        check("oor_no_read", rd_cnt - rd0, 0);

        // Reset landing during ACCESS suppresses the write and the ack.
        wr0 = wr_cnt;
        access(0, 1'b1, 32'd7, 32'hCAFE_F00D, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check("rst_access_gate", {31'b0, ram_write}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_access_ack", {30'b0, ack}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_access_word7", mem[7], shadow[7]);
        check("rst_access_no_wr", wr_cnt - wr0, 0);
        access(0, 1'b0, 32'd7, 32'h0, 1'b1, w);
        check("idle_after_rst", w, 0);
        wait_acks();

        // Reassert in RESP: gnt only once back in IDLE, exactly one extra access.
        hs0 = hs_port.size();
        rd0 = rd_cnt;
        access(0, 1'b0, 32'd6, 32'h0, 1'b1, w);
        @(posedge clk); #1;
        check("resp_ack", {30'b0, ack}, 32'h1);
        addr0 = 32'd5; wr[0] = 1'b0; req[0] = 1'b1;
        sb.push_back('{port: 0, rdata: shadow[5], err: 1'b0});
        acks_expected++;
        #1;
        check("resp_no_gnt", {30'b0, gnt}, 32'h0);
        @(posedge clk); #1;
        check("idle_gnt", {30'b0, gnt}, 32'h1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_acks();
        repeat (4) @(posedge clk);
        #1;
        check("reassert_hs", hs_port.size() - hs0, 2);
        check("reassert_reads", rd_cnt - rd0, 2);

        // Contention from reset: both ports hold req.
`ifdef MEM_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 0, 1};
`endif
        rst_n = 1'b0;
        addr0 = 32'd5; addr1 = 32'd6; wr = 2'b00; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{port: order[k], rdata: (order[k] == 0) ? shadow[5] : shadow[6], err: 1'b0});
            acks_expected++;
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        hs0 = hs_port.size();
        hsi = 0;
        while (hs_port.size() < hs0 + 4 && hsi < 40) begin
            @(posedge clk); #1;
            hsi++;
        end
        req = 2'b00;
        check("contention_hs_count", hs_port.size() - hs0, 4);
        if (hs_port.size() >= hs0 + 4) begin
            for (int k = 0; k < 4; k++) check("grant_order", hs_port[hs0+k], order[k]);
            for (int k = 1; k < 4; k++) check("hs_spacing", hs_cyc[hs0+k] - hs_cyc[hs0+k-1], 3);
        end
        wait_acks();
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
